// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request side and a valid/ready result side.
// Define ALU_MC_MULDIV_EN to build in the iterative MUL/DIVU/REMU datapath.
module alu_mc #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     ALUZero
);

  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_PASSB = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL   = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA   = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'(4'b1111);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]   single_res;
  logic [SHW-1:0]          shamt;

  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (Operation)
      OP_AND:   single_res = SrcA & SrcB;
      OP_XOR:   single_res = SrcA ^ SrcB;
      OP_SUB:   single_res = SrcA - SrcB;
      OP_OR:    single_res = SrcA | SrcB;
      OP_ADD:   single_res = SrcA + SrcB;
      OP_EQ:    single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLL:   single_res = SrcA << shamt;
      OP_PASSB: single_res = SrcB;
      OP_SRL:   single_res = SrcA >> shamt;
      OP_SRA:   single_res = DATA_WIDTH'($signed(SrcA) >>> shamt);
      OP_SLT:   single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU:  single_res = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default:  single_res = '0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_DIVU = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_REMU = OPCODE_LENGTH'(4'b0111);

  // acc holds the running product or partial remainder; opa is multiplicand
  // or divisor; opb is multiplier or the dividend/quotient shift register.
  logic [SHW-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic                  mul_q, mul_d, rem_q, rem_d;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH-1:0] rem_sub;

  assign rem_shift = {acc_q, opb_q[DATA_WIDTH-1]};
  assign rem_sub   = rem_shift[DATA_WIDTH-1:0] - opa_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      mul_q   <= 1'b0;
      rem_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mul_q   <= mul_d;
      rem_q   <= rem_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_MC_MULDIV_EN
    count_d  = count_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mul_d    = mul_q;
    rem_d    = rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = DONE;
          result_d = single_res;
`ifdef ALU_MC_MULDIV_EN
          if (Operation == OP_MUL || Operation == OP_DIVU || Operation == OP_REMU) begin
            if (Operation != OP_MUL && SrcB == '0) begin
              result_d = (Operation == OP_DIVU) ? '1 : SrcA;
            end else begin
              state_d = BUSY;
              count_d = '0;
              acc_d   = '0;
              mul_d   = (Operation == OP_MUL);
              rem_d   = (Operation == OP_REMU);
              opa_d   = (Operation == OP_MUL) ? SrcA : SrcB;
              opb_d   = (Operation == OP_MUL) ? SrcB : SrcA;
            end
          end
`endif
        end
      end
      BUSY: begin
`ifdef ALU_MC_MULDIV_EN
        if (mul_q) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else if (rem_shift >= {1'b0, opa_q}) begin
          acc_d = rem_sub;
          opb_d = {opb_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[DATA_WIDTH-1:0];
          opb_d = {opb_q[DATA_WIDTH-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        // The final iteration writes its result directly on the way into DONE.
        if (count_q == SHW'(DATA_WIDTH - 1)) begin
          state_d  = DONE;
          result_d = (mul_q || rem_q) ? acc_d : opb_d;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = reset && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUResult = result_q;
  assign ALUZero   = (result_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard of expected results and latencies,
// directed corner cases plus a short random mix.
module tb_alu_mc;

  localparam int W = 32;
`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA, SrcB;
  logic [3:0]   Operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         ALUZero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] result;
    int           latency;
  } expect_t;

  expect_t sbQueue[$];

  alu_mc #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .ALUZero   (ALUZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value against its expectation and tallies it.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written straight from the opcode table.
  function automatic logic [W-1:0] modelAlu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'h0: return a & b;
      4'h1: return a ^ b;
      4'h2: return a - b;
      4'h3: return a | b;
      4'h4: return a + b;
      4'h5: return MD ? a * b : '0;
      4'h6: return MD ? ((b == 0) ? '1 : a / b) : '0;
      4'h7: return MD ? ((b == 0) ? a : a % b) : '0;
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'h9: return a << sh;
      4'hA: return b;
      4'hC: return a >> sh;
      4'hD: return $signed(a) >>> sh;
      4'hE: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hF: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  function automatic int modelLatency(input logic [3:0] op, input logic [W-1:0] b);
    if (MD && (op == 4'h5 || ((op == 4'h6 || op == 4'h7) && b != 0))) return W + 1;
    return 1;
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    expect_t e;
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    e.result  = modelAlu(op, a, b);
    e.latency = modelLatency(op, b);
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    Operation = 4'($urandom_range(0, 15));
  endtask

  task automatic collectResult(input string tag);
    expect_t e;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) checkOutput({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    end while (!out_valid && n < 200);
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput({tag, "_latency"}, 64'(n), 64'(e.latency));
    checkOutput({tag, "_result"}, 64'(ALUResult), 64'(e.result));
    checkOutput({tag, "_zero"}, 64'(ALUZero), 64'(e.result == '0));
    if (out_ready) begin
      @(negedge clk);
      checkOutput({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
      checkOutput({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    applyStimulus(op, a, b);
    collectResult(tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_result"}, 64'(ALUResult), 64'd0);
    checkOutput({tag, "_zero"}, 64'(ALUZero), 64'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [3:0]   rop;
    int           sawValid;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    SrcA      = '0;
    SrcB      = '0;
    Operation = '0;
    #1;
    checkResetState("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);

    runOp("add_ovf", 4'h4, 32'h7FFF_FFFF, 32'h0000_0001);
    runOp("slt", 4'hE, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("sltu", 4'hF, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("sra", 4'hD, 32'h8000_0000, 32'h0000_0021);
    runOp("and", 4'h0, 32'hF0F0_1234, 32'h0FF0_FF00);
    runOp("xor", 4'h1, 32'hAAAA_5555, 32'hFFFF_0000);
    runOp("sub_zero", 4'h2, 32'h1234_5678, 32'h1234_5678);
    runOp("or", 4'h3, 32'h0000_00F0, 32'h0F00_0000);
    runOp("eq_true", 4'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    runOp("eq_false", 4'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEE);
    runOp("sll", 4'h9, 32'h0000_0003, 32'hFFFF_FFE4);
    runOp("srl", 4'hC, 32'h8000_0000, 32'h0000_001F);
    runOp("passb", 4'hA, 32'h1111_1111, 32'hCAFE_F00D);
    runOp("undef", 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("mul", 4'h5, 32'h0001_0003, 32'h0002_0005);
    runOp("divu", 4'h6, 32'd100, 32'd7);
    runOp("remu", 4'h7, 32'd100, 32'd7);
    runOp("divu_by0", 4'h6, 32'd5, 32'd0);
    runOp("remu_by0", 4'h7, 32'd5, 32'd0);

    for (int i = 0; i < 12; i++) begin
      rop = 4'($urandom_range(0, 15));
      runOp("rand", rop, $urandom, (i % 4 == 3) ? 32'd0 : $urandom);
    end

    // Result must hold in DONE while the consumer stalls; new requests are ignored.
    out_ready = 1'b0;
    runOp("hold", 4'h4, 32'd10, 32'd20);
    held = ALUResult;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      Operation = 4'h2;
      SrcA      = $urandom;
      SrcB      = $urandom;
      @(negedge clk);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_result", 64'(ALUResult), 64'd30);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("hold_release_valid", 64'(out_valid), 64'd0);
    sawValid = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) sawValid++;
    end
    checkOutput("hold_no_extra_result", 64'(sawValid), 64'd0);
    checkOutput("hold_result_kept", 64'(ALUResult), 64'(held));

    // Reset partway through a long division must discard it.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = 4'h6;
    SrcA      = 32'd100;
    SrcB      = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetState("mid_reset");
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    sawValid  = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (out_valid) sawValid++;
    end
    checkOutput("mid_reset_no_result", 64'(sawValid), 64'd0);
    runOp("add_after_reset", 4'h4, 32'd2, 32'd3);
    checkOutput("add_after_reset_const", 64'(ALUResult), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
